// File: rtl/fft_bfly_dif.sv
// fft_bfly_dif: pipelined radix-2 DIF butterfly for one FFT stage, 3-cycle latency.
// Define FFT_BFLY_SAT_EN for saturating W-bit output reduction (default wraps).
module fft_bfly_dif #(
  parameter int NFFT  = 32,
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int STAGE = 0,
  parameter int SCALE = 1,
  localparam int KW   = $clog2(NFFT / 2)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [W-1:0] i_a_re,
  input  logic signed [W-1:0] i_a_im,
  input  logic signed [W-1:0] i_b_re,
  input  logic signed [W-1:0] i_b_im,
  output logic [KW-1:0]       o_tw_addr,
  input  logic signed [W-1:0] i_tw_re,
  input  logic signed [W-1:0] i_tw_im,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [W-1:0] o_x_re,
  output logic signed [W-1:0] o_x_im,
  output logic signed [W-1:0] o_y_re,
  output logic signed [W-1:0] o_y_im,
  output logic                o_last
);

  localparam int SW = W + 1;
  localparam int PW = 2 * W + 1;
  localparam int YW = 2 * W + 2;

  localparam logic [KW-1:0] KMAX  = KW'(NFFT / 2 - 1);
  localparam logic [KW-1:0] MMASK = KW'((NFFT >> (STAGE + 1)) - 1);

  localparam logic signed [YW-1:0] RND =
    {{(YW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

`ifdef FFT_BFLY_SAT_EN
  localparam logic signed [YW-1:0] MAXV =
    {{(YW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [YW-1:0] MINV =
    {{(YW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  function automatic logic signed [W-1:0] red(
    input logic signed [YW-1:0] v
  );
    if (v > MAXV) begin
      red = MAXV[W-1:0];
    end else if (v < MINV) begin
      red = MINV[W-1:0];
    end else begin
      red = v[W-1:0];
    end
  endfunction
`else
  function automatic logic signed [W-1:0] red(
    input logic signed [YW-1:0] v
  );
    red = v[W-1:0];
  endfunction
`endif

  // pair counter
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;
  logic          acc;

  // P1: sum/diff and captured twiddle
  logic                v1_q;
  logic                l1_q;
  logic signed [SW-1:0] sr_d, si_d, dr_d, di_d;
  logic signed [SW-1:0] sr1_q, si1_q, dr1_q, di1_q;
  logic signed [W-1:0]  tr1_q, ti1_q;

  // P2: products
  logic                 v2_q;
  logic                 l2_q;
  logic signed [SW-1:0] sr2_q, si2_q;
  logic signed [PW-1:0] prr_d, pii_d, pri_d, pir_d;
  logic signed [PW-1:0] prr_q, pii_q, pri_q, pir_q;

  // P3: combine, round, reduce
  logic signed [YW-1:0] yr_d, yi_d;
  logic signed [YW-1:0] yr_s, yi_s;
  logic signed [YW-1:0] xr_w, xi_w;

  assign o_ready   = i_ready;
  assign acc       = i_valid & i_ready;
  assign o_tw_addr = (k_q & MMASK) << STAGE;

  always_comb begin
    k_d = k_q;
    if (acc) begin
      k_d = (k_q == KMAX) ? '0 : k_q + 1'b1;
    end
  end

  always_comb begin
    sr_d = SW'(i_a_re) + SW'(i_b_re);
    si_d = SW'(i_a_im) + SW'(i_b_im);
    dr_d = SW'(i_a_re) - SW'(i_b_re);
    di_d = SW'(i_a_im) - SW'(i_b_im);
    if (SCALE != 0) begin
      sr_d = sr_d >>> 1;
      si_d = si_d >>> 1;
      dr_d = dr_d >>> 1;
      di_d = di_d >>> 1;
    end
  end

  always_comb begin
    prr_d = PW'(dr1_q) * PW'(tr1_q);
    pii_d = PW'(di1_q) * PW'(ti1_q);
    pri_d = PW'(dr1_q) * PW'(ti1_q);
    pir_d = PW'(di1_q) * PW'(tr1_q);
  end

  always_comb begin
    yr_d = YW'(prr_q) - YW'(pii_q) + RND;
    yi_d = YW'(pri_q) + YW'(pir_q) + RND;
    yr_s = yr_d >>> FRAC;
    yi_s = yi_d >>> FRAC;
    xr_w = YW'(sr2_q);
    xi_w = YW'(si2_q);
  end

  // every register holds while downstream stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q     <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      sr1_q   <= '0;
      si1_q   <= '0;
      dr1_q   <= '0;
      di1_q   <= '0;
      tr1_q   <= '0;
      ti1_q   <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      sr2_q   <= '0;
      si2_q   <= '0;
      prr_q   <= '0;
      pii_q   <= '0;
      pri_q   <= '0;
      pir_q   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_x_re  <= '0;
      o_x_im  <= '0;
      o_y_re  <= '0;
      o_y_im  <= '0;
    end else if (i_ready) begin
      k_q     <= k_d;
      v1_q    <= i_valid;
      l1_q    <= i_valid & (k_q == KMAX);
      sr1_q   <= sr_d;
      si1_q   <= si_d;
      dr1_q   <= dr_d;
      di1_q   <= di_d;
      tr1_q   <= i_tw_re;
      ti1_q   <= i_tw_im;
      v2_q    <= v1_q;
      l2_q    <= l1_q;
      sr2_q   <= sr1_q;
      si2_q   <= si1_q;
      prr_q   <= prr_d;
      pii_q   <= pii_d;
      pri_q   <= pri_d;
      pir_q   <= pir_d;
      o_valid <= v2_q;
      o_last  <= l2_q;
      o_x_re  <= red(xr_w);
      o_x_im  <= red(xi_w);
      o_y_re  <= red(yr_s);
      o_y_im  <= red(yi_s);
    end
  end

endmodule

// File: tb/tb_fft_bfly_dif.sv
// tb_fft_bfly_dif: random and directed stimulus on two butterfly
// configurations, checked against an arithmetic reference model.
module tb_fft_bfly_dif;

  localparam int  NFFT = 32;
  localparam int  W    = 16;
  localparam int  FRAC = 14;
  localparam int  KW   = 4;
  localparam int  NP   = NFFT / 2;
  localparam real PI   = 3.14159265358979;

`ifdef FFT_BFLY_SAT_EN
  localparam int T5X = 32767;
`else
  localparam int T5X = -2;
`endif

  typedef struct {
    int are;
    int aim;
    int bre;
    int bim;
    int k;
  } pair_t;

  logic clk = 1'b0;
  logic rst, vld, rdy;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;

  logic [KW-1:0]       addr [2];
  logic signed [W-1:0] twr  [2];
  logic signed [W-1:0] twi  [2];
  logic signed [W-1:0] xr   [2];
  logic signed [W-1:0] xi   [2];
  logic signed [W-1:0] yr   [2];
  logic signed [W-1:0] yi   [2];
  logic                ov   [2];
  logic                ol   [2];
  logic                ordy [2];

  logic signed [W-1:0] rom_re [NP];
  logic signed [W-1:0] rom_im [NP];

  pair_t hist[$];
  int    rd [2];
  bit    stall [2];
  int    k_m;
  int    n_run;
  int    n_fail;

  always #5 clk = ~clk;

  assign twr[0] = rom_re[addr[0]];
  assign twi[0] = rom_im[addr[0]];
  assign twr[1] = rom_re[addr[1]];
  assign twi[1] = rom_im[addr[1]];

  fft_bfly_dif #(
    .NFFT(NFFT), .W(W), .FRAC(FRAC), .STAGE(0), .SCALE(0)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(ordy[0]),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .o_tw_addr(addr[0]), .i_tw_re(twr[0]), .i_tw_im(twi[0]),
    .o_valid(ov[0]), .i_ready(rdy),
    .o_x_re(xr[0]), .o_x_im(xi[0]), .o_y_re(yr[0]), .o_y_im(yi[0]),
    .o_last(ol[0])
  );

  fft_bfly_dif #(
    .NFFT(NFFT), .W(W), .FRAC(FRAC), .STAGE(2), .SCALE(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(ordy[1]),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .o_tw_addr(addr[1]), .i_tw_re(twr[1]), .i_tw_im(twi[1]),
    .o_valid(ov[1]), .i_ready(rdy),
    .o_x_re(xr[1]), .o_x_im(xi[1]), .o_y_re(yr[1]), .o_y_im(yi[1]),
    .o_last(ol[1])
  );

  function automatic int stg(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit scl(input int d);
    return d != 0;
  endfunction

  function automatic int exp_addr(input int k, input int d);
    return (k % (NFFT >> (stg(d) + 1))) << stg(d);
  endfunction

  function automatic longint red(input longint v);
`ifdef FFT_BFLY_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return longint'(shortint'(v));
`endif
  endfunction

  task automatic chk(
    input string              tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_head(input int d);
    pair_t  p;
    longint sr, si, dr, di, tr, ti, y_r, y_i;
    int     ad;
    chk($sformatf("avail%0d", d), hist.size() > rd[d], 1);
    if (hist.size() > rd[d]) begin
      p  = hist[rd[d]];
      ad = exp_addr(p.k, d);
      tr = rom_re[ad];
      ti = rom_im[ad];
      sr = p.are + p.bre;
      si = p.aim + p.bim;
      dr = p.are - p.bre;
      di = p.aim - p.bim;
      if (scl(d)) begin
        sr = sr >>> 1;
        si = si >>> 1;
        dr = dr >>> 1;
        di = di >>> 1;
      end
      y_r = (dr * tr - di * ti + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      y_i = (dr * ti + di * tr + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      chk($sformatf("x_re%0d", d), xr[d], red(sr));
      chk($sformatf("x_im%0d", d), xi[d], red(si));
      chk($sformatf("y_re%0d", d), yr[d], red(y_r));
      chk($sformatf("y_im%0d", d), yi[d], red(y_i));
      chk($sformatf("last%0d", d), ol[d], p.k == NP - 1);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), ordy[d], rdy);
        if (stall[d]) chk($sformatf("hold_v%0d", d), ov[d], 1);
        if (vld && rdy)
          chk($sformatf("tw_addr%0d", d), addr[d], exp_addr(k_m, d));
        if (ov[d]) begin
          check_head(d);
          if (rdy) rd[d]++;
        end
        stall[d] = ov[d] && !rdy;
      end
      if (vld && rdy) begin
        hist.push_back('{int'(a_re), int'(a_im), int'(b_re), int'(b_im), k_m});
        k_m = (k_m + 1) % NP;
      end
    end else begin
      hist.delete();
      rd    = '{0, 0};
      stall = '{0, 0};
      k_m   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    a_re = W'($urandom);
    a_im = W'($urandom);
    b_re = W'($urandom);
    b_im = W'($urandom);
  endtask

  task automatic stream(input int n, input int vpct, input bit r);
    for (int i = 0; i < n; i++) begin
      rnd_in();
      vld = ($urandom_range(99) < vpct);
      rdy = r;
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      rom_re[i] = W'($rtoi($floor(
        16384.0 * $cos(2.0 * PI * real'(i) / real'(NFFT)) + 0.5)));
      rom_im[i] = W'($rtoi($floor(
        -16384.0 * $sin(2.0 * PI * real'(i) / real'(NFFT)) + 0.5)));
    end
    n_run  = 0;
    n_fail = 0;
    k_m    = 0;
    rd     = '{0, 0};
    stall  = '{0, 0};
    rst    = 1'b1;
    vld    = 1'b1;
    rdy    = 1'b1;
    rnd_in();
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_v%0d", d), ov[d], 0);
      chk($sformatf("rst_l%0d", d), ol[d], 0);
      chk($sformatf("rst_xr%0d", d), xr[d], 0);
      chk($sformatf("rst_yi%0d", d), yi[d], 0);
      chk($sformatf("rst_addr%0d", d), addr[d], 0);
    end
    rst = 1'b0;

    a_re = 16'sd1000;
    a_im = 16'sd0;
    b_re = 16'sd200;
    b_im = 16'sd0;
    vld  = 1'b1;
    cyc();
    vld = 1'b0;
    cyc();
    cyc();
    chk("basic_v", ov[0], 1);
    chk("basic_xr", xr[0], 1200);
    chk("basic_xi", xi[0], 0);
    chk("basic_yr", yr[0], 800);
    chk("basic_yi", yi[0], 0);

    a_re = 16'sd32767;
    a_im = 16'sd0;
    b_re = 16'sd32767;
    b_im = 16'sd0;
    vld  = 1'b1;
    cyc();
    vld = 1'b0;
    cyc();
    cyc();
    chk("ovf_v", ov[0], 1);
    chk("ovf_xr", xr[0], T5X);
    chk("ovf_yr", yr[0], 0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    stream(16, 100, 1'b1);
    stream(4, 0, 1'b1);

    stream(6, 100, 1'b1);
    stream(5, 100, 1'b0);
    stream(6, 100, 1'b1);
    stream(4, 0, 1'b1);

    stream(7, 100, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_addr0", addr[0], 0);
    chk("mid_rst_addr1", addr[1], 0);
    stream(8, 100, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rnd_in();
      vld = ($urandom_range(3) != 0);
      rdy = ($urandom_range(4) != 0);
      cyc();
    end

    vld = 1'b0;
    rdy = 1'b1;
    repeat (6) cyc();
    for (int d = 0; d < 2; d++)
      chk($sformatf("drain%0d", d), rd[d], hist.size());

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
